// File: rtl/bakery_pkg.sv
// bakery_pkg: shared types and constants for the bakery ticket arbiter.
// Imported by bakery_min_select and bakery_ticket_arbiter.
package bakery_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_OWN
  } req_state;

  localparam int TICKET_NONE = 0;

endpackage

// File: rtl/bakery_min_select.sv
// bakery_min_select: lexicographic minimum of {ticket, index} over valid
// entries; ties resolve to the lower index because the scan is ascending.
module bakery_min_select
  import bakery_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int TKW = 3
) (
  input  logic [N-1:0]          valid,
  input  logic [N-1:0][TKW-1:0] ticket,
  output logic [IDW-1:0]        winner,
  output logic                  found
);

  logic [TKW-1:0] best;

  // ascending scan keeps the first (lowest index) of equal tickets
  always_comb begin
    found  = 1'b0;
    winner = '0;
    best   = TKW'(TICKET_NONE);
    for (int i = 0; i < N; i++) begin
      if (valid[i] && (!found || ticket[i] < best)) begin
        found  = 1'b1;
        best   = ticket[i];
        winner = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/bakery_ticket_arbiter.sv
// bakery_ticket_arbiter: bakery-style ticket arbiter with drain on wrap.
// Optional macro HOLD_LIMIT_EN bounds ownership to HOLD_MAX cycles.
module bakery_ticket_arbiter
  import bakery_pkg::*;
#(
  parameter int NPROC    = 4,
  parameter int IDW      = 2,
  parameter int TKW      = 3,
  parameter int HOLD_MAX = 15
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NPROC-1:0] req,
  // release is a reserved word in SystemVerilog, hence rel
  input  logic [NPROC-1:0] rel,
  output logic [NPROC-1:0] grant,
  output logic             grant_valid,
  output logic [IDW-1:0]   grant_id,
  output logic             drain,
  output logic             forced_release
);

  localparam logic [TKW-1:0] TNONE = TKW'(TICKET_NONE);
  localparam logic [TKW-1:0] TONE  = TKW'(1);
  localparam logic [TKW-1:0] TMAX  = '1;

  req_state                  st [NPROC];
  logic [NPROC-1:0][TKW-1:0] tk;
  logic [TKW-1:0]            next_ticket;

  logic [NPROC-1:0] issue;
  logic [NPROC-1:0] waiting;
  logic [NPROC-1:0] own;
  logic [NPROC-1:0] tk_live;
  logic             owner_any;
  logic             owner_rel;
  logic             any_issue;
  logic             all_clear;
  logic             found;
  logic             select_en;
  logic             limit_hit;
  logic [IDW-1:0]   winner;

  // per-requester status decode
  always_comb begin
    issue   = '0;
    waiting = '0;
    own     = '0;
    tk_live = '0;
    for (int i = 0; i < NPROC; i++) begin
      issue[i]   = (st[i] == R_IDLE) && req[i] && !drain;
      waiting[i] = (st[i] == R_WAIT) && req[i];
      own[i]     = (st[i] == R_OWN);
      tk_live[i] = (tk[i] != TNONE);
    end
  end

  assign owner_any = |own;
  assign owner_rel = |(own & rel);
  assign any_issue = |issue;
  assign all_clear = ~|tk_live;
  assign select_en = found && !owner_any;

  bakery_min_select #(
    .N   (NPROC),
    .IDW (IDW),
    .TKW (TKW)
  ) u_min (
    .valid  (waiting),
    .ticket (tk),
    .winner (winner),
    .found  (found)
  );

`ifdef HOLD_LIMIT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);

  logic [CW-1:0] hold_cnt;

  assign limit_hit = owner_any && !owner_rel &&
                     (hold_cnt == CW'(HOLD_MAX - 1));

  // ownership cycle counter and preemption pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt       <= '0;
      forced_release <= 1'b0;
    end else begin
      forced_release <= limit_hit;
      if (select_en)
        hold_cnt <= '0;
      else if (owner_any && !limit_hit)
        hold_cnt <= hold_cnt + CW'(1);
    end
  end
`else
  assign limit_hit      = 1'b0;
  assign forced_release = 1'b0;
`endif

  // requester FSMs, dispenser, drain and registered grant
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NPROC; i++)
        st[i] <= R_IDLE;
      tk          <= '0;
      next_ticket <= TONE;
      drain       <= 1'b0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      for (int i = 0; i < NPROC; i++) begin
        unique case (st[i])
          R_IDLE: begin
            if (issue[i]) begin
              st[i] <= R_WAIT;
              tk[i] <= next_ticket;
            end
          end
          R_WAIT: begin
            if (!req[i]) begin
              st[i] <= R_IDLE;
              tk[i] <= TNONE;
            end else if (select_en && winner == IDW'(i)) begin
              st[i] <= R_OWN;
            end
          end
          R_OWN: begin
            if (rel[i] || limit_hit) begin
              st[i] <= R_IDLE;
              tk[i] <= TNONE;
            end
          end
          default: begin
            st[i] <= R_IDLE;
            tk[i] <= TNONE;
          end
        endcase
      end

      if (select_en) begin
        grant       <= NPROC'(1) << winner;
        grant_valid <= 1'b1;
        grant_id    <= winner;
      end else if (owner_rel || limit_hit) begin
        grant       <= '0;
        grant_valid <= 1'b0;
        grant_id    <= '0;
      end

      if (drain && all_clear) begin
        drain       <= 1'b0;
        next_ticket <= TONE;
      end else if (any_issue) begin
        if (next_ticket == TMAX)
          drain <= 1'b1;
        else
          next_ticket <= next_ticket + TONE;
      end
    end
  end

endmodule

// File: tb/tb_bakery_ticket_arbiter.sv
// tb_bakery_ticket_arbiter: directed scenarios plus random traffic,
// checked against a queue-free ticket model with TKW=2 and HOLD_MAX=3.
module tb_bakery_ticket_arbiter;

  localparam int NP   = 4;
  localparam int IW   = 2;
  localparam int TW   = 2;
  localparam int HM   = 3;
  localparam int TMAX = (1 << TW) - 1;
`ifdef HOLD_LIMIT_EN
  localparam bit HL = 1'b1;
`else
  localparam bit HL = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic [NP-1:0] req;
  logic [NP-1:0] rel;
  logic [NP-1:0] grant;
  logic          grant_valid;
  logic [IW-1:0] grant_id;
  logic          drain;
  logic          forced_release;

  always #5 clock = ~clock;

  bakery_ticket_arbiter #(
    .NPROC    (NP),
    .IDW      (IW),
    .TKW      (TW),
    .HOLD_MAX (HM)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req            (req),
    .rel            (rel),
    .grant          (grant),
    .grant_valid    (grant_valid),
    .grant_id       (grant_id),
    .drain          (drain),
    .forced_release (forced_release)
  );

  int passed = 0;
  int total  = 0;

  int m_tk   [NP];
  bit m_wait [NP];
  int m_own;
  int m_nt;
  bit m_drain;
  bit m_fr;
  int m_hold;

  function automatic void m_reset();
    for (int i = 0; i < NP; i++) begin
      m_tk[i]   = 0;
      m_wait[i] = 1'b0;
    end
    m_own   = -1;
    m_nt    = 1;
    m_drain = 1'b0;
    m_fr    = 1'b0;
    m_hold  = 0;
  endfunction

  function automatic void m_step(input logic [NP-1:0] r,
                                 input logic [NP-1:0] rl);
    int sel = -1;
    int o   = m_own;
    bit d   = m_drain;
    int nt0 = m_nt;
    bit allz = 1'b1;
    bit issued = 1'b0;
    for (int i = 0; i < NP; i++)
      if (m_tk[i] != 0) allz = 1'b0;
    if (o < 0)
      for (int i = 0; i < NP; i++)
        if (m_wait[i] && r[i])
          if (sel < 0 || m_tk[i] < m_tk[sel]) sel = i;
    m_fr = 1'b0;
    if (o >= 0) begin
      if (rl[o]) begin
        m_own = -1;
        m_tk[o] = 0;
      end else begin
        m_hold++;
        if (HL && m_hold == HM) begin
          m_own = -1;
          m_tk[o] = 0;
          m_fr = 1'b1;
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (i != o) begin
        if (m_wait[i]) begin
          if (!r[i]) begin
            m_wait[i] = 1'b0;
            m_tk[i] = 0;
          end else if (sel == i) begin
            m_wait[i] = 1'b0;
            m_own = i;
            m_hold = 0;
          end
        end else if (r[i] && !d) begin
          m_wait[i] = 1'b1;
          m_tk[i] = nt0;
          issued = 1'b1;
        end
      end
    end
    if (d && allz) begin
      m_drain = 1'b0;
      m_nt = 1;
    end else if (issued) begin
      if (nt0 == TMAX) m_drain = 1'b1;
      else m_nt = nt0 + 1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_grant"}, 32'(grant),
        (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
    chk({tag, "_valid"}, 32'(grant_valid), 32'(m_own >= 0));
    chk({tag, "_id"}, 32'(grant_id),
        (m_own >= 0) ? 32'(m_own) : 32'd0);
    chk({tag, "_drain"}, 32'(drain), 32'(m_drain));
    chk({tag, "_forced"}, 32'(forced_release), 32'(m_fr));
  endtask

  task automatic cyc(input logic [NP-1:0] r, input logic [NP-1:0] rl);
    req = r;
    rel = rl;
    @(posedge clock);
    m_step(r, rl);
    #1;
    check_model("model");
  endtask

  task automatic do_reset();
    req = '0;
    rel = '0;
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_id", 32'(grant_id), 32'd0);
    chk("rst_drain", 32'(drain), 32'd0);
    chk("rst_forced", 32'(forced_release), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  logic [NP-1:0] rq;
  logic [NP-1:0] rr;

  initial begin
    do_reset();

    // single requester
    cyc(4'b0100, 4'b0000);
    chk("single_nogrant", 32'(grant), 32'd0);
    cyc(4'b0100, 4'b0000);
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_id", 32'(grant_id), 32'd2);
    cyc(4'b0100, 4'b0000);
    cyc(4'b0100, 4'b0000);
    cyc(4'b0100, 4'b0100);
    chk("single_release", 32'(grant), 32'd0);
    cyc(4'b0000, 4'b0000);

    // tie goes to lower index, then one-cycle gap
    do_reset();
    cyc(4'b1010, 4'b0000);
    cyc(4'b1010, 4'b0000);
    chk("tie_first", 32'(grant), 32'h2);
    cyc(4'b1000, 4'b0010);
    chk("tie_gap", 32'(grant_valid), 32'd0);
    cyc(4'b1000, 4'b0000);
    chk("tie_second", 32'(grant_id), 32'd3);
    cyc(4'b0000, 4'b1000);
    cyc(4'b0000, 4'b0000);

    // FIFO order 0,3,1 with wrap into drain
    do_reset();
    cyc(4'b0001, 4'b0000);
    cyc(4'b1001, 4'b0000);
    chk("fifo_first", 32'(grant_id), 32'd0);
    cyc(4'b1011, 4'b0000);
    chk("wrap_drain_set", 32'(drain), 32'd1);
    cyc(4'b1011, 4'b0000);
    cyc(4'b1010, 4'b0001);
    chk("fifo_gap", 32'(grant_valid), 32'd0);
    cyc(4'b1010, 4'b0000);
    chk("fifo_second", 32'(grant_id), 32'd3);
    cyc(4'b1011, 4'b0000);
    cyc(4'b0011, 4'b1000);
    cyc(4'b0011, 4'b0000);
    chk("fifo_third", 32'(grant_id), 32'd1);
    chk("drain_hold", 32'(drain), 32'd1);
    cyc(4'b0001, 4'b0010);
    chk("drain_still", 32'(drain), 32'd1);
    cyc(4'b0001, 4'b0000);
    chk("drain_clear", 32'(drain), 32'd0);
    cyc(4'b0101, 4'b0000);
    cyc(4'b0101, 4'b0000);
    chk("after_drain_grant", 32'(grant), 32'h1);
    cyc(4'b0100, 4'b0001);
    cyc(4'b0100, 4'b0000);
    chk("after_drain_next", 32'(grant), 32'h4);
    cyc(4'b0000, 4'b0100);

    // withdrawal and non-owner release
    do_reset();
    cyc(4'b0001, 4'b0000);
    cyc(4'b0011, 4'b0000);
    cyc(4'b0001, 4'b0000);
    cyc(4'b0001, 4'b1110);
    chk("nonowner_rel", 32'(grant), 32'h1);
    cyc(4'b0000, 4'b0001);
    cyc(4'b0000, 4'b0000);
    chk("withdrawn_nogrant", 32'(grant_valid), 32'd0);

`ifdef HOLD_LIMIT_EN
    // hold limit preemption
    do_reset();
    cyc(4'b0101, 4'b0000);
    cyc(4'b0101, 4'b0000);
    chk("hold_grant", 32'(grant), 32'h1);
    cyc(4'b0101, 4'b0000);
    cyc(4'b0101, 4'b0000);
    chk("hold_still", 32'(grant), 32'h1);
    cyc(4'b0100, 4'b0000);
    chk("hold_drop", 32'(grant), 32'd0);
    chk("hold_forced", 32'(forced_release), 32'd1);
    cyc(4'b0100, 4'b0000);
    chk("hold_next", 32'(grant), 32'h4);
    chk("hold_pulse_end", 32'(forced_release), 32'd0);
    cyc(4'b0000, 4'b0100);
`endif

    // asynchronous reset while granted and draining
    do_reset();
    cyc(4'b0001, 4'b0000);
    cyc(4'b0011, 4'b0000);
    cyc(4'b0111, 4'b0000);
    chk("pre_rst_drain", 32'(drain), 32'd1);
    #3;
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_valid", 32'(grant_valid), 32'd0);
    chk("async_drain", 32'(drain), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    req = '0;

    // random traffic against the model
    do_reset();
    rq = '0;
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NP; i++)
        if ($urandom_range(0, 5) == 0) rq[i] = ~rq[i];
      rr = '0;
      if (m_own >= 0 && $urandom_range(0, 3) == 0) rr[m_own] = 1'b1;
      if ($urandom_range(0, 9) == 0) rr[$urandom_range(0, NP - 1)] = 1'b1;
      cyc(rq, rr);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bakery_ticket_arbiter.md
Name: bakery_ticket_arbiter

Overview:
- Hardware bakery-style arbiter sharing one critical resource among NPROC requesters.
- Each requester takes a numbered ticket on request. The resource is granted to the lowest non-zero ticket; equal tickets go to the lower index.
- Ticket exhaustion is handled by draining, so mutual exclusion holds for any finite ticket width.
- Sits between the requesting process models and the shared resource. It replaces the nondeterministic interleaving used in the bakery process model.

Parameters:
- NPROC, 4, number of requesters.
- IDW, 2, width of the requester index; must hold NPROC-1.
- TKW, 3, ticket width. Ticket 0 means "no ticket"; valid tickets are 1..2^TKW-1.
- HOLD_MAX, 15, maximum ownership cycles; used only with HOLD_LIMIT_EN.

Ports:
- clock, input, 1, sole clock; all state updates on posedge.
- reset_n, input, 1, asynchronous active-low reset.
- req, input, NPROC, level request per requester.
- release, input, NPROC, one-cycle release pulse from the current owner.
- grant, output, NPROC, registered one-hot grant; at most one bit set.
- grant_valid, output, 1, OR of grant.
- grant_id, output, IDW, index of the owner; 0 when grant_valid=0.
- drain, output, 1, dispenser is stalled waiting for outstanding tickets to clear.
- forced_release, output, 1, one-cycle pulse on hold-limit preemption; tied 0 without HOLD_LIMIT_EN.

Behaviour:
- Reset (async, reset_n=0):
  - All requesters go to R_IDLE; all tickets = 0; next_ticket = 1.
  - grant=0, grant_valid=0, grant_id=0, drain=0, forced_release=0.
- Per-requester FSM:
  - R_IDLE -> R_WAIT when req=1 and drain=0. The requester latches ticket = next_ticket.
  - R_WAIT -> R_IDLE when req drops: withdrawal, ticket cleared to 0.
  - R_WAIT -> R_OWN when selected.
  - R_OWN -> R_IDLE on release, or on hold-limit preemption. Ticket cleared to 0.
  - A requester whose req is still high after leaving R_OWN spends at least one cycle in R_IDLE before it takes a new ticket.
- Dispensing:
  - Every requester entering R_WAIT in the same cycle receives the same ticket.
  - next_ticket increments by 1 if at least one ticket was issued that cycle.
- Wrap rule:
  - If next_ticket = 2^TKW-1 and a ticket is issued, drain is set to 1 on the next cycle and no further tickets are issued.
  - drain clears, and next_ticket reloads to 1, in the cycle after all tickets are 0.
  - Never compare across a wrap.
- Selection:
  - Applies when no requester is in R_OWN, no release is occurring, and at least one requester is in R_WAIT.
  - Winner = minimum of {ticket, index} over R_WAIT requesters.
  - grant is registered: it appears the cycle after selection.
- Latency:
  - req rises at edge t; ticket latched at t+1; grant earliest at t+2 if the resource is free.
  - release at edge t: grant drops at t+1; the next grant is earliest at t+2. There is always a one-cycle gap with no owner.
- Ignored inputs:
  - release from a non-owner.
  - req while in R_OWN.
  - Simultaneous release and withdrawal by different requesters are both honoured.
- Reset mid-operation: immediate clear of all state, including drain and any grant.

Optional Feature:
- Macro HOLD_LIMIT_EN.
- Defined:
  - A cycle counter of width clog2(HOLD_MAX+1) counts ownership cycles.
  - When the owner holds for HOLD_MAX cycles without release, grant drops and forced_release pulses for 1 cycle. The owner returns to R_IDLE with its ticket cleared.
  - A release arriving in the same cycle as the limit takes priority, and no forced_release is generated.
- Undefined: no counter exists; forced_release is tied to 0; ownership is unbounded.

Decomposition:
- Package bakery_pkg holds:
  - typedef enum req_state {R_IDLE, R_WAIT, R_OWN};
  - constant TICKET_NONE = 0.
- Sub-module bakery_min_select: combinational lexicographic minimum over the {valid, ticket, index} vectors. Outputs winner index and found flag.

Test Plan:
- Single requester: req[2]=1 at cycle 0 -> ticket 1 at cycle 1, grant=4'b0100 and grant_id=2 at cycle 2; release at cycle 5 -> grant=0 at cycle 6.
- Tie:
  - req[3] and req[1] rise together -> both get ticket 1; grant goes to 1 first.
  - After release, grant goes to 3 with a one-cycle gap.
- FIFO order:
  - req[0] at cycle 0, req[3] at cycle 1, req[1] at cycle 2 -> tickets 1,2,3.
  - Grants in order 0,3,1 regardless of index.
- Wrap/drain (TKW=2):
  - Three staggered requests get tickets 1,2,3; drain=1.
  - A fourth req is held off in R_IDLE until all are released.
  - Then next_ticket=1 and the fourth receives ticket 1.
- Withdrawal and ignores:
  - A waiter drops req -> its ticket is cleared and it is never granted.
  - A non-owner release pulse -> no change to grant.
- HOLD_LIMIT_EN with HOLD_MAX=3: owner never releases -> grant drops after 3 cycles, forced_release=1 for one cycle, next waiter granted the following cycle.
- Async reset mid-grant: reset_n low between edges -> all outputs 0 immediately.
